// File: rtl/rs485_frame_echo.sv
// Half-duplex RS485 frame echo: buffers an rx frame (closed by terminator or silence gap), waits a bus turnaround, then replays it to the tx.
// Optional build macro RS485_ADDR_FILTER_EN: reply only to frames whose first byte is NODE_ADDR (8'hFF = silent broadcast).
module rs485_frame_echo #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 6,
    parameter int unsigned       GAP_TICKS  = 560,
    parameter int unsigned       TURN_TICKS = 160,
    parameter int unsigned       USE_TERM   = 1,
    parameter logic [DATA_W-1:0] TERM_BYTE  = 8'h0D,
    parameter logic [DATA_W-1:0] NODE_ADDR  = 8'h01
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tx_idle,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_en,
    output logic [ADDR_W:0]   frame_len,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned     GAP_W    = $clog2(GAP_TICKS);
    localparam int unsigned     TURN_W   = $clog2(TURN_TICKS + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_TICKS - 1);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_L   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_FILT, S_TURN, S_SEND_REQ, S_SEND_ACK, S_SEND_DONE
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, frame_len_q, frame_len_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
    logic [1:0]        ack_cnt_q, ack_cnt_d;
    logic              overflow_q, overflow_d, tx_en_q, tx_en_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              mem_we, rd_en;
    logic [ADDR_W-1:0] mem_wa;
`ifdef RS485_ADDR_FILTER_EN
    logic [DATA_W-1:0] addr_q, addr_d;
`endif

    // A first byte equal to the terminator never closes: termination is only checked in RECV.
    logic rx_term, rx_close, wr_full, turn_done, send_last;
    assign rx_term   = (USE_TERM != 0) && rx_valid && (rx_data == TERM_BYTE);
    assign rx_close  = rx_term || (!rx_valid && (gap_cnt_q == GAP_LAST));
    assign wr_full   = (wr_ptr_q == DEPTH_L);
    assign turn_done = (turn_cnt_q == TURN_LAST);
    assign send_last = ((rd_ptr_q + PTR_ONE) == frame_len_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            gap_cnt_q   <= '0;
            turn_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= '0;
`ifdef RS485_ADDR_FILTER_EN
            addr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            frame_len_q <= frame_len_d;
            overflow_q  <= overflow_d;
            tx_en_q     <= tx_en_d;
            if (rd_en) tx_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
`ifdef RS485_ADDR_FILTER_EN
            addr_q      <= addr_d;
`endif
        end
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= rx_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (rx_valid) state_d = S_RECV;
`ifdef RS485_ADDR_FILTER_EN
            S_RECV:      if (rx_close) state_d = S_FILT;
            S_FILT:      state_d = (addr_q == NODE_ADDR) ? S_TURN : S_IDLE;
`else
            S_RECV:      if (rx_close) state_d = S_TURN;
`endif
            S_TURN:      if (turn_done) state_d = S_SEND_REQ;
            S_SEND_REQ:  if (tx_idle) state_d = S_SEND_ACK;
            S_SEND_ACK:  if (!tx_idle || (ack_cnt_q == 2'd3)) state_d = S_SEND_DONE;
            S_SEND_DONE: if (tx_idle) state_d = send_last ? S_IDLE : S_SEND_REQ;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        gap_cnt_d   = gap_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        frame_len_d = frame_len_q;
        overflow_d  = overflow_q;
        tx_en_d     = 1'b0;
        rd_en       = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = '0;
`ifdef RS485_ADDR_FILTER_EN
        addr_d      = addr_q;
`endif
        case (state_q)
            S_IDLE: if (rx_valid) begin
                mem_we     = 1'b1;
                wr_ptr_d   = PTR_ONE;
                overflow_d = 1'b0;
                gap_cnt_d  = '0;
`ifdef RS485_ADDR_FILTER_EN
                addr_d     = rx_data;
`endif
            end
            S_RECV: begin
                if (rx_valid) begin
                    gap_cnt_d = '0;
                    if (wr_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        mem_wa   = wr_ptr_q[ADDR_W-1:0];
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
                if (rx_close) begin
                    turn_cnt_d = '0;
`ifndef RS485_ADDR_FILTER_EN
                    frame_len_d = wr_ptr_d;
`endif
                end
            end
`ifdef RS485_ADDR_FILTER_EN
            S_FILT: if ((addr_q == NODE_ADDR) || (addr_q == {DATA_W{1'b1}})) frame_len_d = wr_ptr_q;
`endif
            S_TURN: begin
                turn_cnt_d = turn_cnt_q + TURN_ONE;
                if (turn_done) rd_ptr_d = '0;
            end
            S_SEND_REQ: if (tx_idle) begin
                tx_en_d   = 1'b1;
                rd_en     = 1'b1;
                ack_cnt_d = '0;
            end
            S_SEND_ACK:  if (tx_idle) ack_cnt_d = ack_cnt_q + 2'd1;
            S_SEND_DONE: if (tx_idle) rd_ptr_d = rd_ptr_q + PTR_ONE;
            default: ;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign frame_len = frame_len_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs485_frame_echo.sv
// Bench for rs485_frame_echo: randomized frames, queue scoreboard, model of frame closing, truncation and addressing.
`timescale 1ns/1ps
module tb_rs485_frame_echo;
    localparam int         GAP   = 40;
    localparam int         TURN  = 12;
    localparam int         DEPTH = 64;
    localparam logic [7:0] TERM  = 8'h0D;
    localparam logic [7:0] NODE  = 8'h01;
`ifdef RS485_ADDR_FILTER_EN
    localparam int FILT_CYC = 1;
`else
    localparam int FILT_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_idle = 1'b1;
    logic [7:0] tx_data;
    logic       tx_en;
    logic [6:0] frame_len;
    logic       overflow;
    logic       busy;

    typedef struct { logic [7:0] dat; bit first; } exp_t;
    exp_t       exp_q[$];
    int         t_q[$];
    logic [7:0] frame_q[$];
    int         tests = 0, fails = 0, cyc = 0, tx_count = 0;
    bit         tx_drop_en = 1'b1;
    logic [6:0] exp_len = '0;
    logic       exp_ovf = 1'b0;

    rs485_frame_echo #(
        .DATA_W(8), .ADDR_W(6), .GAP_TICKS(GAP), .TURN_TICKS(TURN),
        .USE_TERM(1), .TERM_BYTE(TERM), .NODE_ADDR(NODE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_idle(tx_idle), .tx_data(tx_data), .tx_en(tx_en),
        .frame_len(frame_len), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == TERM);
        return b;
    endfunction

    // Monitor: every tx strobe pops one expected byte; a frame's first byte also checks its timing.
    initial begin : monitor
        exp_t e;
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_en = 1'b0;
            end else begin
                if (tx_en === 1'b1) begin
                    tx_count++;
                    chk("tx_en_width", {31'd0, prev_en}, 0);
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_tx: got byte 0x%0h, want no strobe (cycle %0d)", tx_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", {24'd0, tx_data}, {24'd0, e.dat});
                        if (e.first) begin
                            if (t_q.size() == 0) begin
                                tests++; fails++;
                                $display("FAIL first_tx_time: got strobe at %0d, want no timing entry", cyc);
                            end else begin
                                chk("first_tx_time", cyc, t_q.pop_front());
                            end
                        end
                    end
                end
                prev_en = tx_en;
            end
        end
    end

    // Transmitter model: goes busy shortly after each strobe, unless told to never acknowledge.
    initial begin : xmit
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1 && reset_n && tx_drop_en) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                tx_idle = 1'b0;
                repeat ($urandom_range(2, 8)) @(negedge clk);
                tx_idle = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Model: a frame ends at the first terminator after byte 0, or at silence; only DEPTH bytes survive.
    task automatic run_frame(input bit inject, input bit boundary, input int stop_after);
        int n, keep, last_edge, base, budget;
        bit by_term, reply;
        n = frame_q.size();
        by_term = 1'b0;
        for (int i = 1; i < frame_q.size(); i++) begin
            if (frame_q[i] == TERM) begin
                by_term = 1'b1;
                n = i + 1;
                break;
            end
        end
        keep  = (n > DEPTH) ? DEPTH : n;
        reply = 1'b1;
`ifdef RS485_ADDR_FILTER_EN
        reply = (frame_q[0] == NODE);
        if (frame_q[0] == NODE || frame_q[0] == 8'hFF) exp_len = 7'(keep);
`else
        exp_len = 7'(keep);
`endif
        exp_ovf = (n > DEPTH);
        if (reply)
            for (int i = 0; i < keep; i++) exp_q.push_back('{dat: frame_q[i], first: (i == 0)});
        base = tx_count;
        for (int i = 0; i < n; i++) begin
            send_byte(frame_q[i]);
            if (i < n - 1) repeat (boundary ? GAP - 2 : int'($urandom_range(0, 3))) @(negedge clk);
        end
        last_edge = cyc;
        if (reply) t_q.push_back(last_edge + (by_term ? 0 : GAP) + TURN + 1 + FILT_CYC);
        if (inject) begin
            budget = GAP + TURN + 100;
            while (tx_count == base && budget > 0) begin @(negedge clk); #2; budget--; end
            chk("inject_wait", {31'd0, (tx_count > base)}, 1);
            for (int k = 0; k < 5; k++) send_byte((k == 2) ? TERM : 8'($urandom_range(0, 255)));
        end
        if (stop_after > 0) begin
            budget = GAP + TURN + 200;
            while (tx_count < base + stop_after && budget > 0) begin @(negedge clk); #2; budget--; end
            chk("stop_wait", {31'd0, (tx_count >= base + stop_after)}, 1);
            return;
        end
        budget = GAP + TURN + 16 * DEPTH + 100;
        while (busy !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        chk("busy_low", {31'd0, busy}, 0);
        chk("frame_len", {25'd0, frame_len}, {25'd0, exp_len});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("replay_left", exp_q.size(), 0);
        chk("timing_left", t_q.size(), 0);
        exp_q.delete();
        t_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of run, want summary before cycle 90000");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int len;
        repeat (2) @(negedge clk);
        chk("rst_tx_en", {31'd0, tx_en}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_frame_len", {25'd0, frame_len}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        frame_q = {8'h01, 8'h41, 8'h42, TERM};
        run_frame(0, 0, 0);
        frame_q = {8'h01, 8'h02, 8'h03};
        run_frame(0, 0, 0);

        frame_q.delete();
        for (int i = 0; i < 70; i++) frame_q.push_back(8'(i + 16));
        frame_q[0] = NODE;
        run_frame(0, 0, 0);

        // Bytes land exactly on gap expiry: they extend the frame instead of closing it.
        frame_q = {NODE, 8'h5A, 8'hA5};
        run_frame(0, 1, 0);

        frame_q = {NODE};
        for (int i = 0; i < 9; i++) frame_q.push_back(rnd_byte());
        frame_q.push_back(TERM);
        run_frame(1, 0, 0);

        tx_drop_en = 1'b0;
        frame_q = {NODE, rnd_byte(), rnd_byte(), rnd_byte(), TERM};
        run_frame(0, 0, 0);
        tx_drop_en = 1'b1;

        frame_q = {TERM, 8'h22, TERM};
        run_frame(0, 0, 0);

        frame_q = {NODE};
        for (int i = 0; i < 65; i++) frame_q.push_back(rnd_byte());
        frame_q.push_back(TERM);
        run_frame(0, 0, 0);

        frame_q = {8'h02, 8'hAA, TERM};
        run_frame(0, 0, 0);
        frame_q = {8'hFF, 8'hAA, TERM};
        run_frame(0, 0, 0);
        frame_q = {8'h01, 8'hAA, TERM};
        run_frame(0, 0, 0);

        frame_q = {8'h01, 8'h41, 8'h42, TERM};
        run_frame(0, 0, 2);
        reset_n = 1'b0;
        exp_len = '0;
        exp_ovf = 1'b0;
        exp_q.delete();
        t_q.delete();
        #1;
        chk("midrst_tx_en", {31'd0, tx_en}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_frame_len", {25'd0, frame_len}, 0);
        chk("midrst_overflow", {31'd0, overflow}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        frame_q = {8'h55, TERM};
        run_frame(0, 0, 0);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 20);
            frame_q = {NODE};
            for (int i = 1; i < len; i++) frame_q.push_back(rnd_byte());
            if ($urandom_range(0, 1) == 1) frame_q.push_back(TERM);
            run_frame(0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
